// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C memory target: FSM state encoding,
// ACK/NACK bus levels and the pointer-width helper.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_PTR,
        ST_WR_DATA,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    localparam logic ACK_LVL  = 1'b0;
    localparam logic NACK_LVL = 1'b1;

    // Pointer width for a memory of 'depth' bytes; PTR_W in the top is derived from this.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Bus line conditioner: 2-flop synchroniser, then a level filter that only
// follows the line after FILTER_LEN identical samples; emits rise/fall pulses.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0]            sync_reg;
    logic [FILTER_LEN-1:0] hist_reg;
    logic [FILTER_LEN-1:0] hist_next;
    logic                  level_reg;
    logic                  level_d_reg;

    genvar gi;
    generate
        for (gi = 0; gi < FILTER_LEN; gi++) begin : g_hist
            if (gi == 0) begin : g_first
                assign hist_next[gi] = sync_reg[1];
            end else begin : g_next
                assign hist_next[gi] = hist_reg[gi-1];
            end
        end
    endgenerate

    // Everything presets to 1 so an idle bus produces no edges out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg    <= 2'b11;
            hist_reg    <= '1;
            level_reg   <= 1'b1;
            level_d_reg <= 1'b1;
        end else begin
            sync_reg    <= {sync_reg[0], line};
            hist_reg    <= hist_next;
            level_d_reg <= level_reg;
            if (&hist_reg) begin
                level_reg <= 1'b1;
            end else if (~|hist_reg) begin
                level_reg <= 1'b0;
            end
        end
    end

    assign level = level_reg;
    assign rise  = level_reg & ~level_d_reg;
    assign fall  = ~level_reg & level_d_reg;

endmodule

// File: rtl/i2c_target_mem.sv
// I2C target with a small byte memory: pointer write, sequential write and
// read with auto-increment, optional SCL stretching after each ACK bit.
module i2c_target_mem
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR       = 7'h50,
    parameter int         MEM_DEPTH      = 16,
    parameter int         FILTER_LEN     = 3,
    parameter int         STRETCH_CYCLES = 0,
    localparam int        PTR_W          = ptr_width(MEM_DEPTH)
) (
    input  logic             wb_clk_i,
    input  logic             arst_i,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             scl_oe_o,
    output logic             sda_oe_o,
    output logic             busy_o,
    output logic             wr_stb_o,
    output logic [PTR_W-1:0] wr_addr_o,
    output logic [7:0]       wr_data_o
);

    localparam int SC_W = (STRETCH_CYCLES > 0) ? $clog2(STRETCH_CYCLES + 1) : 1;
    localparam logic [SC_W-1:0] STRETCH_LOAD = SC_W'(STRETCH_CYCLES);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk   (wb_clk_i),
        .rst_n (arst_i),
        .line  (scl_i),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk   (wb_clk_i),
        .rst_n (arst_i),
        .line  (sda_i),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    state_t           state_reg, state_next;
    logic [3:0]       bit_cnt_reg, bit_cnt_next;
    logic [7:0]       shift_reg, shift_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next, ptr_inc;
    logic             ack_reg, ack_next;
    logic             sda_oe_reg, sda_oe_next;
    logic             busy_reg, busy_next;
    logic             wr_stb_reg, wr_stb_next;
    logic [PTR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [7:0]       wr_data_reg, wr_data_next;
    logic [SC_W-1:0]  stretch_cnt_reg;
    logic             mem_we, stretch_go, stretch_clr;
    logic [7:0]       mem_reg [MEM_DEPTH];
    logic [7:0]       rd_byte_cur, rd_byte_inc;
    logic             start_evt, stop_evt;

    assign start_evt   = sda_fall & scl_lvl;
    assign stop_evt    = sda_rise & scl_lvl;
    assign ptr_inc     = ptr_reg + 1'b1;
    assign rd_byte_cur = mem_reg[ptr_reg];
    assign rd_byte_inc = mem_reg[ptr_inc];

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            ptr_reg     <= '0;
            ack_reg     <= NACK_LVL;
            sda_oe_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            wr_stb_reg  <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            ptr_reg     <= ptr_next;
            ack_reg     <= ack_next;
            sda_oe_reg  <= sda_oe_next;
            busy_reg    <= busy_next;
            wr_stb_reg  <= wr_stb_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_reg[i] <= 8'h00;
            end
        end else if (mem_we) begin
            mem_reg[ptr_reg] <= shift_reg;
        end
    end

    // Stretch counter is loaded on the falling edge that closes an ACK bit;
    // SCL is held low while it is non-zero.
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            stretch_cnt_reg <= '0;
        end else if (stretch_clr) begin
            stretch_cnt_reg <= '0;
        end else if (stretch_go && (STRETCH_CYCLES > 0)) begin
            stretch_cnt_reg <= STRETCH_LOAD;
        end else if (stretch_cnt_reg != '0) begin
            stretch_cnt_reg <= stretch_cnt_reg - 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        ptr_next     = ptr_reg;
        ack_next     = ack_reg;
        sda_oe_next  = sda_oe_reg;
        busy_next    = busy_reg;
        wr_stb_next  = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;
        mem_we       = 1'b0;
        stretch_go   = 1'b0;
        stretch_clr  = 1'b0;

        if (stop_evt) begin
            state_next   = ST_IDLE;
            bit_cnt_next = '0;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
            stretch_clr  = 1'b1;
        end else if (start_evt) begin
            state_next   = ST_ADDR;
            bit_cnt_next = '0;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b1;
            stretch_clr  = 1'b1;
        end else begin
            case (state_reg)
                ST_ADDR: begin
                    if (scl_rise && bit_cnt_reg < 4'd8) begin
                        shift_next   = {shift_reg[6:0], sda_lvl};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                        if (shift_reg[7:1] == DEV_ADDR) begin
                            state_next  = ST_ADDR_ACK;
                            sda_oe_next = 1'b1;
                        end else begin
                            state_next  = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // shift_reg[0] still holds the R/W bit of the address byte.
                    if (scl_fall) begin
                        bit_cnt_next = '0;
                        stretch_go   = 1'b1;
                        if (shift_reg[0]) begin
                            shift_next  = rd_byte_cur;
                            sda_oe_next = ~rd_byte_cur[7];
                            state_next  = ST_RD_BYTE;
                        end else begin
                            sda_oe_next = 1'b0;
                            state_next  = ST_WR_PTR;
                        end
                    end
                end
                ST_WR_PTR, ST_WR_DATA: begin
                    // bit_cnt 9 marks the ACK clock driven by the target.
                    if (scl_rise && bit_cnt_reg < 4'd8) begin
                        shift_next   = {shift_reg[6:0], sda_lvl};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall && bit_cnt_reg == 4'd8) begin
                        sda_oe_next  = 1'b1;
                        bit_cnt_next = 4'd9;
                        if (state_reg == ST_WR_PTR) begin
                            ptr_next = shift_reg[PTR_W-1:0];
                        end else begin
                            mem_we       = 1'b1;
                            wr_stb_next  = 1'b1;
                            wr_addr_next = ptr_reg;
                            wr_data_next = shift_reg;
                            ptr_next     = ptr_inc;
                        end
                    end else if (scl_fall && bit_cnt_reg == 4'd9) begin
                        sda_oe_next  = 1'b0;
                        bit_cnt_next = '0;
                        stretch_go   = 1'b1;
                        state_next   = ST_WR_DATA;
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_reg == 4'd7) begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = '0;
                            state_next   = ST_RD_ACK;
                        end else begin
                            shift_next   = {shift_reg[6:0], 1'b0};
                            sda_oe_next  = ~shift_reg[6];
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        ack_next = sda_lvl;
                    end else if (scl_fall) begin
                        ptr_next     = ptr_inc;
                        bit_cnt_next = '0;
                        stretch_go   = 1'b1;
                        if (ack_reg == ACK_LVL) begin
                            shift_next  = rd_byte_inc;
                            sda_oe_next = ~rd_byte_inc[7];
                            state_next  = ST_RD_BYTE;
                        end else begin
                            sda_oe_next = 1'b0;
                            state_next  = ST_IGNORE;
                        end
                    end
                end
                default: begin
                    sda_oe_next = 1'b0;
                end
            endcase
        end
    end

    assign scl_oe_o  = (stretch_cnt_reg != '0);
    assign sda_oe_o  = sda_oe_reg;
    assign busy_o    = busy_reg;
    assign wr_stb_o  = wr_stb_reg;
    assign wr_addr_o = wr_addr_reg;
    assign wr_data_o = wr_data_reg;

endmodule

// File: tb/tb_i2c_target_mem.sv
// Directed bench for i2c_target_mem: a bit-banged I2C master on a wired-AND
// bus, with monitors for write strobes, SDA drive and SCL stretch lengths.
module tb_i2c_target_mem;

    localparam int Q       = 10;
    localparam int STRETCH = 20;

    logic       wb_clk_i = 1'b0;
    logic       arst_i   = 1'b0;
    logic       scl_m    = 1'b1;
    logic       sda_m    = 1'b1;
    logic       scl_bus, sda_bus;
    logic       scl_oe_o, sda_oe_o, busy_o, wr_stb_o;
    logic [3:0] wr_addr_o;
    logic [7:0] wr_data_o;

    assign scl_bus = scl_m & ~scl_oe_o;
    assign sda_bus = sda_m & ~sda_oe_o;

    always #5 wb_clk_i = ~wb_clk_i;

    i2c_target_mem #(
        .DEV_ADDR       (7'h50),
        .MEM_DEPTH      (16),
        .FILTER_LEN     (3),
        .STRETCH_CYCLES (STRETCH)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .arst_i    (arst_i),
        .scl_i     (scl_bus),
        .sda_i     (sda_bus),
        .scl_oe_o  (scl_oe_o),
        .sda_oe_o  (sda_oe_o),
        .busy_o    (busy_o),
        .wr_stb_o  (wr_stb_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_stretch = 0;
    int          run_len = 0;
    logic        sda_oe_seen = 1'b0;
    logic        glitch_en = 1'b0;
    logic [11:0] wr_log [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge wb_clk_i) begin
        if (arst_i) begin
            if (wr_stb_o) wr_log.push_back({wr_addr_o, wr_data_o});
            if (sda_oe_o) sda_oe_seen = 1'b1;
            if (scl_oe_o) begin
                run_len++;
            end else if (run_len != 0) begin
                check("stretch_len", run_len, STRETCH);
                n_stretch++;
                run_len = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic scl_high();
        int t;
        scl_m = 1'b1;
        t = 0;
        while (scl_bus !== 1'b1 && t < 200) begin
            @(negedge wb_clk_i);
            t++;
        end
        check("scl_release", scl_bus, 1'b1);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        cyc(Q);
        scl_high();
        cyc(Q);
        if (glitch_en) begin
            sda_m = ~b;
            cyc(1);
            sda_m = b;
            cyc(Q - 1);
        end else begin
            cyc(Q);
        end
        scl_m = 1'b0;
        cyc(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1;
        cyc(Q);
        scl_high();
        cyc(Q);
        b = sda_bus;
        cyc(Q);
        scl_m = 1'b0;
        cyc(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        cyc(Q);
        scl_high();
        cyc(Q);
        sda_m = 1'b0;
        cyc(Q);
        scl_m = 1'b0;
        cyc(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        cyc(Q);
        scl_high();
        cyc(Q);
        sda_m = 1'b1;
        cyc(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic nack);
        logic bv;
        b = '0;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(bv);
            b[i] = bv;
        end
        send_bit(nack);
    endtask

    task automatic write_txn(input logic [7:0] ptr, input logic [7:0] d0,
                             input logic [7:0] d1, input logic glitch);
        logic a0, a1, a2, a3;
        i2c_start();
        check("wr_busy_after_start", busy_o, 1'b1);
        send_byte(8'hA0, a0);
        send_byte(ptr, a1);
        glitch_en = glitch;
        send_byte(d0, a2);
        glitch_en = 1'b0;
        send_byte(d1, a3);
        check("wr_acks", {a0, a1, a2, a3}, 4'b0000);
        check("wr_busy_before_stop", busy_o, 1'b1);
        i2c_stop();
        check("wr_busy_after_stop", busy_o, 1'b0);
        $display("TXN write ptr=%02h data=%02h,%02h acks=%b%b%b%b glitch=%0d",
                 ptr, d0, d1, a0, a1, a2, a3, glitch);
    endtask

    task automatic read_txn(input logic [7:0] ptr, input logic [7:0] e0, input logic [7:0] e1);
        logic a0, a1, a2;
        logic [7:0] r0, r1;
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(ptr, a1);
        i2c_start();
        send_byte(8'hA1, a2);
        recv_byte(r0, 1'b0);
        recv_byte(r1, 1'b1);
        check("rd_acks", {a0, a1, a2}, 3'b000);
        check("rd_byte0", r0, e0);
        check("rd_byte1", r1, e1);
        check("rd_release_after_nack", sda_oe_o, 1'b0);
        i2c_stop();
        check("rd_busy_after_stop", busy_o, 1'b0);
        $display("TXN read ptr=%02h data=%02h,%02h acks=%b%b%b", ptr, r0, r1, a0, a1, a2);
    endtask

    initial begin
        logic a0, a1, a2;
        logic bv;

        cyc(5);
        check("rst_scl_oe", scl_oe_o, 1'b0);
        check("rst_sda_oe", sda_oe_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        arst_i = 1'b1;
        cyc(20);
        check("rst_wr_stb", wr_stb_o, 1'b0);
        check("rst_wr_addr", wr_addr_o, 4'h0);
        check("rst_wr_data", wr_data_o, 8'h00);
        $display("TXN reset released");

        // Write with a 1-cycle SDA glitch on every bit of the first data byte.
        write_txn(8'h03, 8'h11, 8'h22, 1'b1);
        check("wr_count_1", wr_log.size(), 2);
        check("wr_log_0", wr_log[0], 12'h311);
        check("wr_log_1", wr_log[1], 12'h422);

        read_txn(8'h03, 8'h11, 8'h22);

        // Foreign address: no ACK, no drive, busy held until STOP.
        sda_oe_seen = 1'b0;
        i2c_start();
        send_byte(8'hA4, a0);
        send_byte(8'h55, a1);
        check("nm_acks", {a0, a1}, 2'b11);
        check("nm_busy_before_stop", busy_o, 1'b1);
        i2c_stop();
        check("nm_busy_after_stop", busy_o, 1'b0);
        check("nm_sda_oe_seen", sda_oe_seen, 1'b0);
        check("nm_wr_count", wr_log.size(), 2);
        $display("TXN addr A4 acks=%b%b sda_driven=%0d", a0, a1, sda_oe_seen);

        write_txn(8'h0F, 8'hAA, 8'hBB, 1'b0);
        check("wrap_wr_count", wr_log.size(), 4);
        check("wrap_log_2", wr_log[2], 12'hFAA);
        check("wrap_log_3", wr_log[3], 12'h0BB);
        read_txn(8'h0F, 8'hAA, 8'hBB);
        check("stretch_count_a", n_stretch, 18);

        // Reset while the target drives bit 6 (0) of mem[0]=0xBB.
        i2c_start();
        send_byte(8'hA0, a0);
        send_byte(8'h00, a1);
        i2c_start();
        send_byte(8'hA1, a2);
        check("mid_acks", {a0, a1, a2}, 3'b000);
        recv_bit(bv);
        check("mid_bit7", bv, 1'b1);
        check("mid_sda_drive_bit6", sda_oe_o, 1'b1);
        #3 arst_i = 1'b0;
        #1;
        check("mid_rst_sda_oe", sda_oe_o, 1'b0);
        check("mid_rst_scl_oe", scl_oe_o, 1'b0);
        check("mid_rst_busy", busy_o, 1'b0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        cyc(5);
        arst_i = 1'b1;
        cyc(20);
        $display("TXN async reset during read");

        write_txn(8'h05, 8'h5A, 8'h6B, 1'b0);
        check("post_wr_count", wr_log.size(), 6);
        check("post_log_4", wr_log[4], 12'h55A);
        check("post_log_5", wr_log[5], 12'h66B);
        read_txn(8'h0F, 8'h00, 8'h00);
        check("stretch_count_b", n_stretch, 30);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
